// File: rtl/key_event_ctrl.sv
// Front-panel key scheduler: grants one debounced key at a time and classifies
// each press as short, long or (with KEY_EVENT_AUTO_REPEAT_EN defined) auto-repeat.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no key owned; waiting for a rising edge on any key
// ST_PRESS | owner held for less than LONG_CYC cycles; release gives a short event
// ST_HELD  | long event already issued; waiting for release (repeats when enabled)
module key_event_ctrl #(
   parameter int NUM_KEYS   = 4,
   parameter int KEY_W      = 2,
   parameter int LONG_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int CNT_W      = 26
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_lvl,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [KEY_W-1:0]    evt_key,
   output logic [1:0]          evt_type,
   output logic                evt_drop,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_HELD  = 2'd2
   } state_t;

   localparam logic [1:0] TYPE_SHORT  = 2'b00;
   localparam logic [1:0] TYPE_LONG   = 2'b01;
   localparam logic [1:0] TYPE_REPEAT = 2'b10;

   localparam int             HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_MAX - 1);
`ifdef KEY_EVENT_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);
`endif

   state_t              state, state_nxt;
   logic [NUM_KEYS-1:0] key_prev;
   logic [NUM_KEYS-1:0] rise;
   logic                rise_any;
   logic [KEY_W-1:0]    rise_idx;
   logic [KEY_W-1:0]    owner, owner_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
   logic                owner_lvl;
   logic                issue;
   logic [1:0]          issue_type;

   assign rise      = key_lvl & ~key_prev;
   assign owner_lvl = key_lvl[owner];
   assign busy      = (state != ST_IDLE);

   // Holds at the largest threshold so the counter can never wrap.
   assign cnt_inc   = (cnt == HOLD_TC) ? cnt : cnt + 1'b1;

   always_comb begin
      rise_any = |rise;
      rise_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (rise[i]) rise_idx = KEY_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         key_prev <= '0;
         owner    <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         key_prev <= key_lvl;
         owner    <= owner_nxt;
         cnt      <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      cnt_nxt    = cnt;
      issue      = 1'b0;
      issue_type = TYPE_SHORT;
      case (state)
         ST_IDLE: begin
            if (rise_any) begin
               owner_nxt = rise_idx;
               cnt_nxt   = '0;
               state_nxt = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (!owner_lvl) begin
               issue      = 1'b1;
               issue_type = TYPE_SHORT;
               cnt_nxt    = '0;
               state_nxt  = ST_IDLE;
            end else if (cnt == LONG_TC) begin
               issue      = 1'b1;
               issue_type = TYPE_LONG;
               cnt_nxt    = '0;
               state_nxt  = ST_HELD;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ST_HELD: begin
            if (!owner_lvl) begin
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end
`ifdef KEY_EVENT_AUTO_REPEAT_EN
            else if (cnt == REPEAT_TC) begin
               issue      = 1'b1;
               issue_type = TYPE_REPEAT;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
`endif
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // A delivery in the same cycle frees the slot, so the new event may load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_key   <= '0;
         evt_type  <= 2'b00;
         evt_drop  <= 1'b0;
      end else begin
         evt_drop <= 1'b0;
         if (issue) begin
            if (!evt_valid || evt_ready) begin
               evt_valid <= 1'b1;
               evt_key   <= owner;
               evt_type  <= issue_type;
            end else begin
               evt_drop <= 1'b1;
            end
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with LONG_CYC=20, REPEAT_CYC=5.
module tb_key_event_ctrl;

   localparam int NUM_KEYS   = 4;
   localparam int KEY_W      = 2;
   localparam int LONG_CYC   = 20;
   localparam int REPEAT_CYC = 5;
   localparam int CNT_W      = 26;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NUM_KEYS-1:0] key_lvl = '0;
   logic                evt_ready = 1'b1;
   logic                evt_valid;
   logic [KEY_W-1:0]    evt_key;
   logic [1:0]          evt_type;
   logic                evt_drop;
   logic                busy;

   int checks = 0;
   int errors = 0;
   logic [3:0] evq[$];
   int drop_cnt = 0;

   always #5 clk = ~clk;

   key_event_ctrl #(
      .NUM_KEYS   (NUM_KEYS),
      .KEY_W      (KEY_W),
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_lvl   (key_lvl),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_key   (evt_key),
      .evt_type  (evt_type),
      .evt_drop  (evt_drop),
      .busy      (busy)
   );

   // Records every handshake that will complete at the coming rising edge.
   always begin
      @(negedge clk);
      #2;
      if (evt_valid && evt_ready) evq.push_back({evt_key, evt_type});
      if (evt_drop) drop_cnt++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      checks++;
      if ({evt_valid, evt_key, evt_type, evt_drop, busy} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000000", {evt_valid, evt_key, evt_type, evt_drop, busy});
      end
      rst_n = 1'b1;
      tick(2);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy got %b want 0", busy);
      end
   endtask

   task automatic test_short();
      evq.delete();
      key_lvl = 4'b0100;
      tick(5);
      checks++;
      if (busy !== 1'b1 || evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL short_pressing busy/valid got %b%b want 10", busy, evt_valid);
      end
      key_lvl = 4'b0000;
      tick();
      checks++;
      if ({evt_valid, evt_key, evt_type} !== 5'b1_10_00) begin
         errors++;
         $display("FAIL short_event got %b want 11000", {evt_valid, evt_key, evt_type});
      end
      tick(5);
      checks++;
      if (evq.size() != 1 || evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL short_count got %0d valid %b want 1 valid 0", evq.size(), evt_valid);
      end
   endtask

   task automatic test_long();
      int exp_n;
      evq.delete();
      drop_cnt = 0;
      key_lvl = 4'b0010;
      tick(20);
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL long_early valid got %b want 0", evt_valid);
      end
      tick();
      checks++;
      if ({evt_valid, evt_key, evt_type} !== 5'b1_01_01) begin
         errors++;
         $display("FAIL long_event got %b want 10101", {evt_valid, evt_key, evt_type});
      end
      tick(19);
      key_lvl = 4'b0000;
      tick(5);
      exp_n = 1;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
      exp_n = 4;
`endif
      checks++;
      if (evq.size() != exp_n) begin
         errors++;
         $display("FAIL long_count got %0d want %0d", evq.size(), exp_n);
      end
      for (int i = 0; i < evq.size(); i++) begin
         checks++;
         if (evq[i] !== ((i == 0) ? 4'b0101 : 4'b0110)) begin
            errors++;
            $display("FAIL long_seq[%0d] got %b want %b", i, evq[i], (i == 0) ? 4'b0101 : 4'b0110);
         end
      end
      checks++;
      if (busy !== 1'b0 || drop_cnt != 0) begin
         errors++;
         $display("FAIL long_release busy %b drops %0d want 0 0", busy, drop_cnt);
      end
   endtask

   task automatic test_simultaneous();
      evq.delete();
      key_lvl = 4'b1001;
      tick(4);
      key_lvl = 4'b0001;
      tick(3);
      checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL simul_nonowner valid %b busy %b want 0 1", evt_valid, busy);
      end
      key_lvl = 4'b0000;
      tick();
      checks++;
      if ({evt_valid, evt_key, evt_type} !== 5'b1_00_00) begin
         errors++;
         $display("FAIL simul_event got %b want 10000", {evt_valid, evt_key, evt_type});
      end
      tick(4);
      checks++;
      if (evq.size() != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL simul_count got %0d busy %b want 1 0", evq.size(), busy);
      end
   endtask

   task automatic test_drop();
      evq.delete();
      drop_cnt = 0;
      evt_ready = 1'b0;
      key_lvl = 4'b0100;
      tick(3);
      key_lvl = 4'b0000;
      tick();
      key_lvl = 4'b0010;
      tick(3);
      key_lvl = 4'b0000;
      tick();
      checks++;
      if ({evt_drop, evt_valid, evt_key, evt_type} !== 6'b1_1_10_00) begin
         errors++;
         $display("FAIL drop_pulse got %b want 111000", {evt_drop, evt_valid, evt_key, evt_type});
      end
      tick();
      checks++;
      if ({evt_drop, evt_valid, evt_key} !== 4'b0_1_10) begin
         errors++;
         $display("FAIL drop_hold got %b want 0110", {evt_drop, evt_valid, evt_key});
      end
      evt_ready = 1'b1;
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_deliver valid got %b want 0", evt_valid);
      end
      tick(3);
      checks++;
      if (evq.size() != 1 || drop_cnt != 1) begin
         errors++;
         $display("FAIL drop_count events %0d drops %0d want 1 1", evq.size(), drop_cnt);
      end else begin
         checks++;
         if (evq[0] !== 4'b1000) begin
            errors++;
            $display("FAIL drop_key got %b want 1000", evq[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      evq.delete();
      drop_cnt = 0;
      evt_ready = 1'b1;
      key_lvl = 4'b0001;
      tick(2);
      key_lvl = 4'b0000;
      tick();
      key_lvl = 4'b0010;
      tick(2);
      key_lvl = 4'b0000;
      tick(4);
      checks++;
      if (evq.size() != 2 || drop_cnt != 0) begin
         errors++;
         $display("FAIL b2b_count events %0d drops %0d want 2 0", evq.size(), drop_cnt);
      end else begin
         checks++;
         if (evq[0] !== 4'b0000 || evq[1] !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_order got %b %b want 0000 0100", evq[0], evq[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      evq.delete();
      key_lvl = 4'b1000;
      tick(10);
      checks++;
      if (busy !== 1'b1 || evt_key !== 2'd1) begin
         errors++;
         $display("FAIL rmid_before busy %b key %0d want 1 1", busy, evt_key);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({evt_valid, evt_key, evt_type, evt_drop, busy} !== 7'b0) begin
         errors++;
         $display("FAIL rmid_async got %b want 0000000", {evt_valid, evt_key, evt_type, evt_drop, busy});
      end
      tick(2);
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rmid_released busy got %b want 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_capture busy got %b want 1", busy);
      end
      tick(4);
      key_lvl = 4'b0000;
      tick();
      checks++;
      if ({evt_valid, evt_key, evt_type} !== 5'b1_11_00) begin
         errors++;
         $display("FAIL rmid_event got %b want 11100", {evt_valid, evt_key, evt_type});
      end
      tick(3);
      checks++;
      if (evq.size() != 1) begin
         errors++;
         $display("FAIL rmid_count got %0d want 1", evq.size());
      end
   endtask

   initial begin
      test_reset();
      test_short();
      tick(3);
      test_long();
      tick(3);
      test_simultaneous();
      tick(3);
      test_drop();
      tick(3);
      test_back_to_back();
      tick(3);
      test_reset_mid();
      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
